// File: rtl/ltssm_pkg.sv
// Shared types and helpers for the LTSSM lane-aggregation fabric.
// FSM state enum, ts_info field positions, qualifier counter width.
package ltssm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } agg_state_e;

  localparam int TS_ST_MSB  = 7;
  localparam int TS_ST_LSB  = 4;
  localparam int TS_SUB_MSB = 3;
  localparam int TS_SUB_LSB = 0;

  function automatic int qual_cnt_w(input int q);
    return (q < 1) ? 1 : $clog2(q + 1);
  endfunction

endpackage

// File: rtl/ltssm_lane_qual.sv
// Saturating per-lane qualifier: counts consecutive cycles of p2c.
// qual is high once the count has reached QUAL_CYC.
module ltssm_lane_qual
  import ltssm_pkg::*;
#(
  parameter int QUAL_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic p2c,
  input  logic clr,
  output logic qual
);

  localparam int W = qual_cnt_w(QUAL_CYC);
  localparam logic [W-1:0] MAX = W'(QUAL_CYC);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !p2c) begin
      cnt_d = '0;
    end else if (cnt_q != MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign qual = (cnt_q == MAX);

endmodule

// File: rtl/ltssm_lane_agg.sv
// N-lane TS-info broadcast / ack collection / p2c qualification.
// Optional lane reversal with LTSSM_LANE_REVERSAL_EN.
module ltssm_lane_agg
  import ltssm_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int INFO_W      = 8,
  parameter int QUAL_CYC    = 4,
  parameter int ACK_TIMEOUT = 1023,
  localparam int CW = $clog2(NUM_LANES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] rx_det,
`ifdef LTSSM_LANE_REVERSAL_EN
  input  logic                 lane_rev,
`endif
  input  logic                 mask_load,
  output logic [NUM_LANES-1:0] lane_mask,
  output logic [CW-1:0]        active_cnt,
  input  logic [INFO_W-1:0]    ts_info,
  input  logic                 ts_update,
  output logic                 ts_update_ack,
  output logic                 busy,
  output logic                 ack_timeout,
  output logic [NUM_LANES-1:0] failed_lanes,
  output logic [INFO_W-1:0]    lane_ts_info,
  output logic [NUM_LANES-1:0] lane_update,
  input  logic [NUM_LANES-1:0] lane_ack_tx,
  input  logic [NUM_LANES-1:0] lane_ack_rx,
  input  logic [NUM_LANES-1:0] lane_p2c,
  output logic                 p2c_all,
  output logic                 p2c_any
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);

  typedef logic [NUM_LANES-1:0] lanes_t;

  agg_state_e state_q, state_d;
  lanes_t mask_q, mask_d;
  lanes_t pend_q, pend_d;
  lanes_t tx_q, tx_d;
  lanes_t rx_q, rx_d;
  lanes_t failed_q, failed_d;
  lanes_t qual;
  logic [TW-1:0] timer_q, timer_d;
  logic [INFO_W-1:0] info_q, info_d;
  logic to_q, to_d;
  logic all_q, all_d;
  logic any_q, any_d;
  logic accept;
  logic rev;
  logic [CW-1:0] cnt;

  function automatic lanes_t lmap(input lanes_t v, input logic r);
    lanes_t o;
    for (int i = 0; i < NUM_LANES; i++) begin
      o[i] = r ? v[NUM_LANES-1-i] : v[i];
    end
    return o;
  endfunction

`ifdef LTSSM_LANE_REVERSAL_EN
  // Orientation only changes between transactions.
  logic rev_q;

  assign rev = (state_q == IDLE) ? lane_rev : rev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rev_q <= 1'b0;
    end else begin
      rev_q <= rev;
    end
  end
`else
  assign rev = 1'b0;
`endif

  lanes_t det_m, atx_m, arx_m, p2c_m;

  assign det_m = lmap(rx_det, rev);
  assign atx_m = lmap(lane_ack_tx, rev);
  assign arx_m = lmap(lane_ack_rx, rev);
  assign p2c_m = lmap(lane_p2c, rev);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    pend_d   = pend_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    failed_d = failed_q;
    timer_d  = timer_q;
    info_d   = info_q;
    to_d     = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mask_load) begin
          mask_d = det_m;
        end
        if (ts_update) begin
          accept   = 1'b1;
          info_d   = ts_info;
          pend_d   = mask_q;
          tx_d     = '0;
          rx_d     = '0;
          timer_d  = '0;
          failed_d = '0;
          state_d  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        pend_d  = pend_q & ~(tx_q & rx_q);
        tx_d    = tx_q | (atx_m & pend_q);
        rx_d    = rx_q | (arx_m & pend_q);
        timer_d = timer_q + 1'b1;
        if (pend_d == '0) begin
          state_d = DONE;
        end else if (timer_q == TMAX) begin
          failed_d = pend_d;
          to_d     = 1'b1;
          pend_d   = '0;
          state_d  = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_qual
    ltssm_lane_qual #(
      .QUAL_CYC(QUAL_CYC)
    ) u_qual (
      .clk (clk),
      .rst (rst),
      .p2c (p2c_m[g]),
      .clr (~mask_q[g] | accept),
      .qual(qual[g])
    );
  end

  always_comb begin
    all_d = (|mask_q) & (&(qual | ~mask_q));
    any_d = |(qual & mask_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mask_q   <= '1;
      pend_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      failed_q <= '0;
      timer_q  <= '0;
      info_q   <= '0;
      to_q     <= 1'b0;
      all_q    <= 1'b0;
      any_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      failed_q <= failed_d;
      timer_q  <= timer_d;
      info_q   <= info_d;
      to_q     <= to_d;
      all_q    <= all_d;
      any_q    <= any_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cnt = cnt + CW'(mask_q[i]);
    end
  end

  assign lane_mask     = mask_q;
  assign active_cnt    = cnt;
  assign lane_update   = pend_q;
  assign lane_ts_info  = info_q;
  assign failed_lanes  = failed_q;
  assign ack_timeout   = to_q;
  assign ts_update_ack = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign p2c_all       = all_q;
  assign p2c_any       = any_q;

endmodule

// File: tb/tb_ltssm_lane_agg.sv
// Directed bench for ltssm_lane_agg with an ack/timeout scoreboard.
// Covers broadcast, timeout, empty mask, qualifier, busy-ignore, reset.
module tb_ltssm_lane_agg;

  localparam int NL = 4;
  localparam int IW = 8;
  localparam int QC = 4;
  localparam int AT = 16;
  localparam int CW = $clog2(NL + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NL-1:0] rx_det = '0;
  logic lane_rev = 1'b0;
  logic mask_load = 1'b0;
  logic [NL-1:0] lane_mask;
  logic [CW-1:0] active_cnt;
  logic [IW-1:0] ts_info = '0;
  logic ts_update = 1'b0;
  logic ts_update_ack;
  logic busy;
  logic ack_timeout;
  logic [NL-1:0] failed_lanes;
  logic [IW-1:0] lane_ts_info;
  logic [NL-1:0] lane_update;
  logic [NL-1:0] lane_ack_tx = '0;
  logic [NL-1:0] lane_ack_rx = '0;
  logic [NL-1:0] lane_p2c = '0;
  logic p2c_all;
  logic p2c_any;

  typedef struct packed {
    logic          to;
    logic [NL-1:0] failed;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  int checks = 0;
  int errors = 0;
  int n_ack = 0;
  int n_to = 0;
  int exp_ack = 0;

  ltssm_lane_agg #(
    .NUM_LANES  (NL),
    .INFO_W     (IW),
    .QUAL_CYC   (QC),
    .ACK_TIMEOUT(AT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_det       (rx_det),
`ifdef LTSSM_LANE_REVERSAL_EN
    .lane_rev     (lane_rev),
`endif
    .mask_load    (mask_load),
    .lane_mask    (lane_mask),
    .active_cnt   (active_cnt),
    .ts_info      (ts_info),
    .ts_update    (ts_update),
    .ts_update_ack(ts_update_ack),
    .busy         (busy),
    .ack_timeout  (ack_timeout),
    .failed_lanes (failed_lanes),
    .lane_ts_info (lane_ts_info),
    .lane_update  (lane_update),
    .lane_ack_tx  (lane_ack_tx),
    .lane_ack_rx  (lane_ack_rx),
    .lane_p2c     (lane_p2c),
    .p2c_all      (p2c_all),
    .p2c_any      (p2c_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 50) begin
      nxt();
      k++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic push(input logic to, input logic [NL-1:0] f);
    e_m.to = to;
    e_m.failed = f;
    sb.push_back(e_m);
    if (!to) exp_ack++;
  endtask

  // Scoreboard side: every ack/timeout pulse must match the oldest entry.
  exp_t got;
  always @(negedge clk) begin
    if (rst && (ts_update_ack || ack_timeout)) begin
      if (ts_update_ack) n_ack++;
      if (ack_timeout) n_to++;
      if (sb.size() == 0) begin
        chk("sb_unexpected", {30'd0, ack_timeout, ts_update_ack}, 32'd0);
      end else begin
        got = sb.pop_front();
        chk("sb_kind", {30'd0, ack_timeout, ts_update_ack},
            got.to ? 32'd2 : 32'd1);
        if (got.to) chk("sb_failed", 32'(failed_lanes), 32'(got.failed));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [NL-1:0] t1_tx [6];
  logic [NL-1:0] t1_rx [6];
  logic [NL-1:0] t1_up [6];
  int lat;

  initial begin
    t1_tx = '{4'b1001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    t1_rx = '{4'b1000, 4'b0001, 4'b0000, 4'b0010, 4'b0100, 4'b0000};
    t1_up = '{4'b0111, 4'b0111, 4'b0110, 4'b0110, 4'b0100, 4'b0000};

    repeat (3) @(negedge clk);
    chk("rst_mask", 32'(lane_mask), 32'hF);
    chk("rst_cnt", 32'(active_cnt), 32'd4);
    chk("rst_info", 32'(lane_ts_info), 32'd0);
    chk("rst_failed", 32'(failed_lanes), 32'd0);
    chk("rst_outs",
        {26'd0, busy, ts_update_ack, ack_timeout,
         p2c_all, p2c_any, |lane_update}, 32'd0);
    rst = 1'b1;
    nxt();

    rx_det = 4'b0111;
    mask_load = 1'b1;
    nxt();
    mask_load = 1'b0;
    chk("t1_mask", 32'(lane_mask), 32'h7);
    chk("t1_cnt", 32'(active_cnt), 32'd3);
    ts_info = 8'h5A;
    ts_update = 1'b1;
    push(1'b0, '0);
    nxt();
    ts_update = 1'b0;
    chk("t1_upd0", 32'(lane_update), 32'h7);
    chk("t1_info", 32'(lane_ts_info), 32'h5A);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int c = 0; c < 6; c++) begin
      lane_ack_tx = t1_tx[c];
      lane_ack_rx = t1_rx[c];
      nxt();
      chk($sformatf("t1_upd_e%0d", c + 1),
          32'(lane_update), 32'(t1_up[c]));
    end
    chk("t1_ack", 32'(ts_update_ack), 32'd1);
    nxt();
    chk("t1_idle", {30'd0, busy, ack_timeout}, 32'd0);

    ts_info = 8'h12;
    ts_update = 1'b1;
    push(1'b1, 4'b0010);
    nxt();
    ts_update = 1'b0;
    lane_ack_tx = 4'b0111;
    lane_ack_rx = 4'b0101;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      nxt();
      if (n == 1) begin
        lane_ack_tx = '0;
        lane_ack_rx = '0;
      end
      if (n == 4) chk("t2_upd", 32'(lane_update), 32'h2);
      if (ack_timeout) begin
        lat = n;
        break;
      end
    end
    chk("t2_lat", lat, 32'd16);
    chk("t2_failed", 32'(failed_lanes), 32'h2);
    chk("t2_drop", {27'd0, busy, lane_update}, 32'd0);
    nxt();
    nxt();
    chk("t2_hold", 32'(failed_lanes), 32'h2);
    chk("t2_pulse", 32'(ack_timeout), 32'd0);

    rx_det = '0;
    mask_load = 1'b1;
    nxt();
    mask_load = 1'b0;
    chk("t3_mask", 32'(lane_mask), 32'd0);
    chk("t3_cnt", 32'(active_cnt), 32'd0);
    lane_p2c = 4'hF;
    ts_update = 1'b1;
    push(1'b0, '0);
    nxt();
    ts_update = 1'b0;
    chk("t3_fclr", 32'(failed_lanes), 32'd0);
    nxt();
    chk("t3_ack", 32'(ts_update_ack), 32'd1);
    repeat (4) nxt();
    chk("t3_p2c", {30'd0, p2c_all, p2c_any}, 32'd0);
    lane_p2c = '0;

    rx_det = 4'hF;
    mask_load = 1'b1;
    nxt();
    mask_load = 1'b0;
    chk("t4_cnt", 32'(active_cnt), 32'd4);
    lane_p2c = 4'b0100;
    repeat (3) nxt();
    lane_p2c = '0;
    nxt();
    nxt();
    chk("t4_short", 32'(p2c_any), 32'd0);
    lane_p2c = 4'b0100;
    repeat (4) nxt();
    chk("t4_pre", 32'(p2c_any), 32'd0);
    nxt();
    chk("t4_any", {30'd0, p2c_all, p2c_any}, 32'd1);
    lane_p2c = 4'hF;
    repeat (4) nxt();
    chk("t4_all_pre", 32'(p2c_all), 32'd0);
    nxt();
    chk("t4_all", 32'(p2c_all), 32'd1);
    lane_p2c = '0;
    nxt();
    nxt();
    chk("t4_clr", {30'd0, p2c_all, p2c_any}, 32'd0);
    lane_p2c = 4'b0100;
    nxt();
    nxt();
    ts_info = 8'h3C;
    ts_update = 1'b1;
    push(1'b0, '0);
    nxt();
    ts_update = 1'b0;
    lane_ack_tx = 4'hF;
    lane_ack_rx = 4'hF;
    nxt();
    lane_ack_tx = '0;
    lane_ack_rx = '0;
    repeat (3) nxt();
    chk("t4_restart", 32'(p2c_any), 32'd0);
    nxt();
    chk("t4_requal", 32'(p2c_any), 32'd1);
    chk("t4_info", 32'(lane_ts_info), 32'h3C);
    lane_p2c = '0;
    wait_idle("t4_idle");

    ts_info = 8'h81;
    ts_update = 1'b1;
    push(1'b0, '0);
    nxt();
    rx_det = 4'b0011;
    mask_load = 1'b1;
    ts_info = 8'hFF;
    nxt();
    ts_update = 1'b0;
    mask_load = 1'b0;
    chk("t5_mask", 32'(lane_mask), 32'hF);
    chk("t5_info", 32'(lane_ts_info), 32'h81);
    chk("t5_busy", 32'(busy), 32'd1);
    lane_ack_tx = 4'hF;
    lane_ack_rx = 4'hF;
    nxt();
    lane_ack_tx = '0;
    lane_ack_rx = '0;
    wait_idle("t5_idle");
    repeat (3) nxt();
    chk("t5_mask2", 32'(lane_mask), 32'hF);

`ifdef LTSSM_LANE_REVERSAL_EN
    lane_rev = 1'b1;
    rx_det = 4'b0001;
    mask_load = 1'b1;
    nxt();
    mask_load = 1'b0;
    chk("rv_mask", 32'(lane_mask), 32'h8);
    ts_update = 1'b1;
    push(1'b0, '0);
    nxt();
    ts_update = 1'b0;
    chk("rv_upd", 32'(lane_update), 32'h8);
    lane_ack_tx = 4'b0001;
    lane_ack_rx = 4'b0001;
    nxt();
    lane_ack_tx = '0;
    lane_ack_rx = '0;
    wait_idle("rv_idle");
    lane_rev = 1'b0;
    rx_det = 4'hF;
    mask_load = 1'b1;
    nxt();
    mask_load = 1'b0;
`endif

    ts_update = 1'b1;
    nxt();
    ts_update = 1'b0;
    chk("t7_upd", 32'(lane_update), 32'hF);
    #2 rst = 1'b0;
    #1;
    chk("t7_async", {27'd0, busy, lane_update}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) nxt();
    chk("t7_mask", 32'(lane_mask), 32'hF);

    chk("acks", n_ack, exp_ack);
    chk("timeouts", n_to, 32'd1);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
